// File: rtl/csr_file_irq_if.sv
// CSR instruction access bus between the decoder (master) and the CSR file (slave).
// Carries the opcode/address/operands in and the combinational read data and illegal flag out.
interface csr_file_irq_if #(
    parameter int XLEN = 32
);
    logic [2:0]      opcode_i;
    logic [11:0]     addr_i;
    logic            write_enable_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] imm_data_i;
    logic [XLEN-1:0] read_data_o;
    logic            illegal_o;

    modport master (
        output opcode_i, addr_i, write_enable_i, rs1_data_i, imm_data_i,
        input  read_data_o, illegal_o
    );

    modport slave (
        input  opcode_i, addr_i, write_enable_i, rs1_data_i, imm_data_i,
        output read_data_o, illegal_o
    );
endinterface

// File: rtl/csr_file_irq.sv
// Machine-mode CSR file with trap/mret handling of mstatus, read-only mip from external
// interrupt lines, masked interrupt requests, mcycle/minstret counters and trap-target logic.
module csr_file_irq #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 64,
    parameter int IRQ_NUM   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    csr_file_irq_if.slave      bus,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               trap_i,
    input  logic [XLEN-1:0]    mcause_i,
    input  logic               mret_i,
    input  logic               instret_i,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic [XLEN-1:0]    mie_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    trap_pc_o,
    output logic               irq_req_o,
    output logic [XLEN-1:0]    irq_cause_o
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("csr_file_irq: only XLEN=32 is supported");
    end
    if (CNT_WIDTH != 32 && CNT_WIDTH != 64) begin : g_bad_cnt
        $error("csr_file_irq: CNT_WIDTH must be 32 or 64");
    end
    if (IRQ_NUM < 1 || IRQ_NUM > 16) begin : g_bad_irq
        $error("csr_file_irq: IRQ_NUM must be 1..16");
    end

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    logic [XLEN-1:0]      mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0]      mepc_q, mepc_d, mcause_q, mcause_d;
    logic                 st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [CNT_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [XLEN-1:0] mip_val, mstatus_val, rdata, src, wdata, pend;
    logic [63:0]     cycle_ext, instret_ext, cycle_next, instret_next;
    logic            mapped, read_only, op_valid, csr_wr;

    // Counters are handled as 64-bit values; a 32-bit build simply drops the upper half.
    assign cycle_ext   = 64'(mcycle_q);
    assign instret_ext = 64'(minstret_q);

    always_comb begin
        mip_val                  = '0;
        mip_val[16 +: IRQ_NUM]   = irq_i;
        mstatus_val              = '0;
        mstatus_val[12:11]       = 2'b11;
        mstatus_val[7]           = st_mpie_q;
        mstatus_val[3]           = st_mie_q;
    end

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (bus.addr_i)
            A_MSTATUS:   rdata = mstatus_val;
            A_MIE:       rdata = mie_q;
            A_MTVEC:     rdata = mtvec_q;
            A_MSCRATCH:  rdata = mscratch_q;
            A_MEPC:      rdata = mepc_q;
            A_MCAUSE:    rdata = mcause_q;
            A_MIP:       begin rdata = mip_val;            read_only = 1'b1; end
            A_MCYCLE:    rdata = cycle_ext[31:0];
            A_MCYCLEH:   rdata = cycle_ext[63:32];
            A_MINSTRET:  rdata = instret_ext[31:0];
            A_MINSTRETH: rdata = instret_ext[63:32];
            A_CYCLE:     begin rdata = cycle_ext[31:0];    read_only = 1'b1; end
            A_CYCLEH:    begin rdata = cycle_ext[63:32];   read_only = 1'b1; end
            A_INSTRET:   begin rdata = instret_ext[31:0];  read_only = 1'b1; end
            A_INSTRETH:  begin rdata = instret_ext[63:32]; read_only = 1'b1; end
            default:     mapped = 1'b0;
        endcase
    end

    always_comb begin
        src = bus.opcode_i[2] ? bus.imm_data_i : bus.rs1_data_i;
        case (bus.opcode_i[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = src | rdata;
            2'b11:   wdata = ~src & rdata;
            default: wdata = rdata;
        endcase
    end

    assign op_valid      = |bus.opcode_i[1:0];
    assign bus.illegal_o = bus.write_enable_i & (~mapped | (op_valid & read_only));
    assign csr_wr        = bus.write_enable_i & op_valid & mapped & ~read_only & ~trap_i;
    assign bus.read_data_o = rdata;

    always_comb begin
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        st_mie_d     = st_mie_q;
        st_mpie_d    = st_mpie_q;
        cycle_next   = cycle_ext + 64'd1;
        instret_next = instret_ext + 64'(instret_i);
        if (csr_wr) begin
            case (bus.addr_i)
                A_MSTATUS: begin
                    if (!mret_i) begin
                        st_mie_d  = wdata[3];
                        st_mpie_d = wdata[7];
                    end
                end
                A_MIE:       mie_d      = wdata;
                A_MTVEC:     mtvec_d    = wdata;
                A_MSCRATCH:  mscratch_d = wdata;
                A_MEPC:      mepc_d     = wdata & ~XLEN'(3);
                A_MCAUSE:    mcause_d   = wdata;
                A_MCYCLE:    cycle_next = {cycle_ext[63:32], wdata};
                A_MCYCLEH:   if (CNT_WIDTH == 64) cycle_next = {wdata, cycle_ext[31:0]};
                A_MINSTRET:  instret_next = {instret_ext[63:32], wdata};
                A_MINSTRETH: if (CNT_WIDTH == 64) instret_next = {wdata, instret_ext[31:0]};
                default:     ;
            endcase
        end
        // A trap beats both mret and any CSR write in the same cycle.
        if (trap_i) begin
            mepc_d    = pc_i & ~XLEN'(3);
            mcause_d  = mcause_i;
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret_i) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
        mcycle_d   = CNT_WIDTH'(cycle_next);
        minstret_d = CNT_WIDTH'(instret_next);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    always_comb begin
        trap_pc_o = {mtvec_q[XLEN-1:2], 2'b00};
        if (mtvec_q[1:0] == 2'b01 && mcause_i[XLEN-1])
            trap_pc_o = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({mcause_i[4:0], 2'b00});
    end

    assign pend      = mip_val & mie_q;
    assign irq_req_o = st_mie_q & (|pend);

    // Scan from the top so the lowest pending line is the one that sticks.
    always_comb begin
        irq_cause_o = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pend[16 + i]) irq_cause_o = {1'b1, (XLEN-1)'(16 + i)};
        end
    end

    assign mie_o  = mie_q;
    assign mepc_o = mepc_q;
endmodule
